// File: rtl/game_io_pkg.sv
// Shared constants for the game I/O slice: register map,
// edge-mode encodings and the default debounce period.
package game_io_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // 10 ms at 50 MHz
    localparam int DEBOUNCE_50MHZ = 500000;

endpackage

// File: rtl/game_key_debounce.sv
// One key channel: two-flop synchroniser followed by a
// stability counter that only accepts persistent changes.
module game_key_debounce
    import game_io_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_50MHZ,
    parameter logic IDLE_LEVEL      = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic stable
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta;
    logic          sync;
    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta   <= IDLE_LEVEL;
            sync   <= IDLE_LEVEL;
            stable <= IDLE_LEVEL;
            count  <= '0;
        end else begin
            meta <= raw;
            sync <= meta;
            if (sync == stable) begin
                count <= '0;
            end else if (count == LAST) begin
                stable <= sync;
                count  <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/game_key_pio.sv
// Avalon-MM input PIO for game keys: debounced data,
// sticky edge capture with write-1-to-clear, masked level IRQ.
module game_key_pio
    import game_io_pkg::*;
#(
    parameter int               WIDTH           = 4,
    parameter int               DEBOUNCE_CYCLES = DEBOUNCE_50MHZ,
    parameter int               EDGE_MODE       = EDGE_FALL,
    parameter logic [WIDTH-1:0] IDLE_LEVEL      = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] clr;
    logic             wr;

    for (genvar i = 0; i < WIDTH; i++) begin : g_key
        game_key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .IDLE_LEVEL     (IDLE_LEVEL[i])
        ) u_debounce (
            .clk    (clk),
            .reset_n(reset_n),
            .raw    (in_port[i]),
            .stable (stable[i])
        );
    end

    assign rise = stable & ~stable_d;
    assign fall = ~stable & stable_d;
    assign edge_det = (EDGE_MODE == EDGE_RISE) ? rise :
                      (EDGE_MODE == EDGE_FALL) ? fall :
                                                 (rise | fall);

    assign wr  = chipselect && !write_n;
    assign clr = (wr && address == ADDR_EDGECAP) ?
                 writedata[WIDTH-1:0] : '0;
    assign irq = |(edgecap & irqmask);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_d <= IDLE_LEVEL;
            irqmask  <= '0;
            edgecap  <= '0;
            readdata <= '0;
        end else begin
            stable_d <= stable;
            if (wr && address == ADDR_IRQMASK) begin
                irqmask <= writedata[WIDTH-1:0];
            end
            // a new edge outranks a clear aimed at the same bit
            edgecap <= (edgecap & ~clr) | edge_det;
            unique case (address)
                ADDR_DATA:    readdata <= 32'(stable);
                ADDR_IRQMASK: readdata <= 32'(irqmask);
                ADDR_EDGECAP: readdata <= 32'(edgecap);
                default:      readdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_game_key_pio.sv
// Directed bench for game_key_pio: one falling-edge and one
// any-edge instance share the bus and key inputs.
module tb_game_key_pio;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] rd_fall;
    logic [31:0] rd_any;
    logic        irq_fall;
    logic        irq_any;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    game_key_pio #(
        .WIDTH(4), .DEBOUNCE_CYCLES(4),
        .EDGE_MODE(1), .IDLE_LEVEL(4'hF)
    ) u_fall (
        .clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rd_fall),
        .in_port(in_port), .irq(irq_fall)
    );

    game_key_pio #(
        .WIDTH(4), .DEBOUNCE_CYCLES(4),
        .EDGE_MODE(2), .IDLE_LEVEL(4'hF)
    ) u_any (
        .clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rd_any),
        .in_port(in_port), .irq(irq_any)
    );

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a,
                             input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a);
        address = a;
        tick(1);
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 4'hF;
        tick(3);
        check("rst_rd", rd_fall, 32'h0);
        check("rst_irq", {31'b0, irq_fall}, 32'h0);
        reset_n = 1'b1;
        tick(3);

        // idle after reset
        bus_read(2'd0); check("idle_data", rd_fall, 32'hF);
        bus_read(2'd2); check("idle_mask", rd_fall, 32'h0);
        bus_read(2'd3); check("idle_ecap", rd_fall, 32'h0);
        check("idle_irq", {31'b0, irq_fall}, 32'h0);

        // press key 0: stable changes exactly 2+4 clocks later
        address = 2'd0;
        in_port = 4'hE;
        tick(6); check("press_early", rd_fall, 32'hF);
        tick(1); check("press_data", rd_fall, 32'hE);
        bus_read(2'd3); check("press_ecap", rd_fall, 32'h1);
        check("press_irq_masked", {31'b0, irq_fall}, 32'h0);

        // 3-cycle glitches on key 1 never get through
        bus_write(2'd3, 32'hF);
        for (int i = 0; i < 5; i++) begin
            in_port = 4'hC; tick(3);
            in_port = 4'hE; tick(3);
        end
        tick(8);
        bus_read(2'd0); check("glitch_data", rd_fall, 32'hE);
        bus_read(2'd3); check("glitch_ecap", rd_fall, 32'h0);

        // mask key 0; a release only shows up in any-edge mode
        bus_write(2'd2, 32'h1);
        bus_read(2'd2); check("mask_rd", rd_fall, 32'h1);
        in_port = 4'hF;
        tick(8);
        bus_read(2'd3);
        check("rel_ecap_fall", rd_fall, 32'h0);
        check("rel_ecap_any", rd_any, 32'h1);
        check("rel_irq_fall", {31'b0, irq_fall}, 32'h0);
        check("rel_irq_any", {31'b0, irq_any}, 32'h1);
        bus_write(2'd3, 32'hF);
        check("clr_irq_any", {31'b0, irq_any}, 32'h0);

        // press key 0 again with irq enabled
        in_port = 4'hE;
        tick(6); check("irq_before", {31'b0, irq_fall}, 32'h0);
        tick(1); check("irq_after", {31'b0, irq_fall}, 32'h1);
        bus_write(2'd3, 32'h2);
        check("wrong_clr_irq", {31'b0, irq_fall}, 32'h1);
        bus_read(2'd3); check("wrong_clr_ecap", rd_fall, 32'h1);
        bus_write(2'd3, 32'h1);
        check("clr_irq", {31'b0, irq_fall}, 32'h0);
        bus_read(2'd3); check("clr_ecap", rd_fall, 32'h0);

        // clear of bit 2 lands on the same edge that captures key 2
        in_port = 4'hA;
        tick(6);
        bus_write(2'd3, 32'h4);
        bus_read(2'd3);
        check("set_wins_fall", rd_fall, 32'h4);
        check("set_wins_any", rd_any, 32'h4);
        check("unmasked_irq", {31'b0, irq_fall}, 32'h0);
        bus_write(2'd2, 32'h4);
        check("mask2_irq", {31'b0, irq_fall}, 32'h1);

        // release key 0 with key 2 still down
        in_port = 4'hB;
        tick(8);
        bus_read(2'd3);
        check("rel0_fall", rd_fall, 32'h4);
        check("rel0_any", rd_any, 32'h5);

        // reset mid-debounce of key 2 release (counter at 2)
        in_port = 4'hF;
        tick(4);
        reset_n = 1'b0;
        #1;
        check("mid_rst_rd", rd_fall, 32'h0);
        check("mid_rst_irq", {31'b0, irq_fall}, 32'h0);
        tick(2);
        reset_n = 1'b1;
        tick(10);
        check("post_irq", {31'b0, irq_any}, 32'h0);
        bus_read(2'd3);
        check("post_ecap_fall", rd_fall, 32'h0);
        check("post_ecap_any", rd_any, 32'h0);
        bus_read(2'd2); check("post_mask", rd_fall, 32'h0);
        bus_read(2'd0); check("post_data", rd_fall, 32'hF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
